// File: rtl/lime_io_bridge_if.sv
// lime_io_bridge_if: core-side and external-side signals of lime_io_bridge.
// Defining LIME_IO_OVF_COUNT_EN adds the ovf_count signal.
interface lime_io_bridge_if #(
    parameter int AW    = 2,
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic             out_wr;
    logic             out_full;
    logic [AW:0]      out_count;
    logic             out_ovf;
    logic             ext_valid;
    logic [WIDTH-1:0] ext_data;
    logic             ext_ready;
    logic             ext_in_valid;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_avail;
    logic             in_rd;
`ifdef LIME_IO_OVF_COUNT_EN
    logic [7:0]       ovf_count;
`endif

    modport slave (
        input  out_data, out_wr, ext_ready, ext_in_valid, ext_in_data, in_rd,
        output out_full, out_count, out_ovf, ext_valid, ext_data, ext_in_ready, in_data, in_avail
`ifdef LIME_IO_OVF_COUNT_EN
        , output ovf_count
`endif
    );

    modport master (
        output out_data, out_wr, ext_ready, ext_in_valid, ext_in_data, in_rd,
        input  out_full, out_count, out_ovf, ext_valid, ext_data, ext_in_ready, in_data, in_avail
`ifdef LIME_IO_OVF_COUNT_EN
        , input ovf_count
`endif
    );
endinterface

// File: rtl/lime_io_bridge.sv
// lime_io_bridge: core I/O bridge with an output FIFO and a one-word input holding register.
// Defining LIME_IO_OVF_COUNT_EN adds a saturating dropped-write counter (ovf_count).
module lime_io_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 16
) (
    input logic             CLK,
    input logic             Reset_n,
    lime_io_bridge_if.slave io
);
    typedef enum logic {EMPTY, HELD} in_state_t;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      count;
    logic             full, valid, push, pop, drop;
    in_state_t        state;
    logic             in_ready, in_avail;
    logic [WIDTH-1:0] in_data;
`ifdef LIME_IO_OVF_COUNT_EN
    logic [7:0]       ovf_count;
`else
    logic             ovf;
`endif

    assign full  = count == FULL_CNT;
    assign valid = count != '0;
    assign pop   = valid & io.ext_ready;
    assign push  = io.out_wr & (~full | pop);
    assign drop  = io.out_wr & full & ~pop;

    assign io.out_full     = full;
    assign io.out_count    = count;
    assign io.ext_valid    = valid;
    assign io.ext_data     = valid ? mem[rp] : '0;
    assign io.ext_in_ready = in_ready;
    assign io.in_avail     = in_avail;
    assign io.in_data      = in_data;
`ifdef LIME_IO_OVF_COUNT_EN
    assign io.ovf_count    = ovf_count;
    assign io.out_ovf      = ovf_count != 8'd0;
`else
    assign io.out_ovf      = ovf;
`endif

    always_ff @(posedge CLK)
        if (push) mem[wp] <= io.out_data;

    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
`ifdef LIME_IO_OVF_COUNT_EN
            ovf_count <= 8'd0;
`else
            ovf   <= 1'b0;
`endif
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
`ifdef LIME_IO_OVF_COUNT_EN
            if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
`else
            if (drop) ovf <= 1'b1;
`endif
        end

    // ready stays low until the first edge after reset release, then tracks EMPTY
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            in_avail <= 1'b0;
            in_data  <= '0;
        end else if (state == EMPTY) begin
            if (in_ready && io.ext_in_valid) begin
                state    <= HELD;
                in_ready <= 1'b0;
                in_avail <= 1'b1;
                in_data  <= io.ext_in_data;
            end else begin
                in_ready <= 1'b1;
            end
        end else if (io.in_rd) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            in_avail <= 1'b0;
        end
endmodule

// File: tb/tb_lime_io_bridge.sv
// tb_lime_io_bridge: directed test-plan scenarios plus randomized traffic against a queue-based model.
module tb_lime_io_bridge;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic CLK = 1'b0;
    logic Reset_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    lime_io_bridge_if #(.AW(AW), .WIDTH(16)) io ();
    lime_io_bridge #(.DEPTH(DEPTH), .AW(AW), .WIDTH(16)) dut (.CLK(CLK), .Reset_n(Reset_n), .io(io));

    always #5 CLK = ~CLK;

    logic [15:0] mq[$];
    logic [15:0] got[$];
    bit          m_ovf, m_held, m_seen;
    int          m_ovfc;
    logic [15:0] m_in;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 0;
        m_ovfc = 0;
        m_held = 0;
        m_in = '0;
        m_seen = 0;
    endtask

    // effect of the coming rising edge, given the inputs just driven
    task automatic model_step();
        bit p, f, w, d;
        if (!Reset_n) return;
        f = mq.size() == DEPTH;
        p = mq.size() != 0 && io.ext_ready;
        w = io.out_wr && (!f || p);
        d = io.out_wr && f && !p;
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(io.out_data);
        if (d) begin
            m_ovf = 1;
            if (m_ovfc != 255) m_ovfc++;
        end
        if (m_seen && !m_held && io.ext_in_valid) begin
            m_held = 1;
            m_in = io.ext_in_data;
        end else if (m_held && io.in_rd) m_held = 0;
        m_seen = 1;
    endtask

    task automatic cyc(bit wr, logic [15:0] wd, bit rdy, bit iv, logic [15:0] id, bit rd);
        @(negedge CLK);
        #1;
        io.out_wr = wr;
        io.out_data = wd;
        io.ext_ready = rdy;
        io.ext_in_valid = iv;
        io.ext_in_data = id;
        io.in_rd = rd;
        if (io.ext_valid && rdy) got.push_back(io.ext_data);
        model_step();
    endtask

    task automatic idle();
        cyc(0, 16'h0, 0, 0, 16'h0, 0);
    endtask

    task automatic reset_seq();
        Reset_n = 0;
        model_clear();
        repeat (2) idle();
        @(negedge CLK);
        #1;
        Reset_n = 1;
        model_step();
    endtask

    always @(negedge CLK) begin
        chk("count", 32'(io.out_count), 32'(mq.size()));
        chk("full", 32'(io.out_full), 32'(mq.size() == DEPTH));
        chk("ovf", 32'(io.out_ovf), 32'(m_ovf));
        chk("valid", 32'(io.ext_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("ext_data", 32'(io.ext_data), 32'(mq[0]));
        chk("in_ready", 32'(io.ext_in_ready), 32'(m_seen && !m_held));
        chk("in_avail", 32'(io.in_avail), 32'(m_held));
        chk("in_data", 32'(io.in_data), 32'(m_in));
`ifdef LIME_IO_OVF_COUNT_EN
        chk("ovf_count", 32'(io.ovf_count), 32'(m_ovfc));
`endif
    end

    initial begin
        io.out_wr = 0; io.out_data = '0; io.ext_ready = 0;
        io.ext_in_valid = 0; io.ext_in_data = '0; io.in_rd = 0;
        model_clear();
        reset_seq();
        idle();
        chk("rst_count", 32'(io.out_count), 0);
        chk("rst_valid", 32'(io.ext_valid), 0);
        chk("rst_data", 32'(io.ext_data), 0);
        chk("rst_ready", 32'(io.ext_in_ready), 1);
        chk("rst_avail", 32'(io.in_avail), 0);
        chk("rst_ovf", 32'(io.out_ovf), 0);

        // 1: three writes then drain
        cyc(1, 16'h1111, 0, 0, 0, 0);
        cyc(1, 16'h2222, 0, 0, 0, 0);
        cyc(1, 16'h3333, 0, 0, 0, 0);
        idle();
        chk("t1_count", 32'(io.out_count), 3);
        chk("t1_head", 32'(io.ext_data), 32'h1111);
        got.delete();
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
        idle();
        chk("t1_valid0", 32'(io.ext_valid), 0);
        chk("t1_n", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("t1_w0", 32'(got[0]), 32'h1111);
            chk("t1_w1", 32'(got[1]), 32'h2222);
            chk("t1_w2", 32'(got[2]), 32'h3333);
        end

        // 2: overflow drops the fifth word
        reset_seq();
        for (int i = 0; i < 5; i++) cyc(1, 16'hA000 + 16'(i), 0, 0, 0, 0);
        idle();
        chk("t2_full", 32'(io.out_full), 1);
        chk("t2_ovf", 32'(io.out_ovf), 1);
`ifdef LIME_IO_OVF_COUNT_EN
        chk("t2_ovfc", 32'(io.ovf_count), 1);
`endif
        got.delete();
        repeat (4) cyc(0, 0, 1, 0, 0, 0);
        idle();
        chk("t2_n", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_w", 32'(got[i]), 32'hA000 + 32'(i));

        // 3: write while full with a pop
        reset_seq();
        for (int i = 0; i < 4; i++) cyc(1, 16'hC000 + 16'(i), 0, 0, 0, 0);
        got.delete();
        cyc(1, 16'hBEEF, 1, 0, 0, 0);
        idle();
        chk("t3_count", 32'(io.out_count), 4);
        chk("t3_ovf", 32'(io.out_ovf), 0);
        repeat (4) cyc(0, 0, 1, 0, 0, 0);
        idle();
        chk("t3_n", 32'(got.size()), 5);
        if (got.size() == 5) chk("t3_last", 32'(got[4]), 32'hBEEF);

        // 4: latency-1 from empty with ready held
        reset_seq();
        got.delete();
        cyc(1, 16'h0042, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t4_valid", 32'(io.ext_valid), 1);
        chk("t4_data", 32'(io.ext_data), 32'h0042);
        idle();
        chk("t4_valid0", 32'(io.ext_valid), 0);
        chk("t4_n", 32'(got.size()), 1);

        // 5: input holding register
        reset_seq();
        cyc(0, 0, 0, 1, 16'h1234, 0);
        cyc(0, 0, 0, 1, 16'h1234, 0);
        chk("t5_avail", 32'(io.in_avail), 1);
        chk("t5_data", 32'(io.in_data), 32'h1234);
        chk("t5_ready0", 32'(io.ext_in_ready), 0);
        cyc(0, 0, 0, 1, 16'h1234, 0);
        cyc(0, 0, 0, 1, 16'h5678, 0);
        cyc(0, 0, 0, 1, 16'h5678, 1);
        chk("t5_keep", 32'(io.in_data), 32'h1234);
        cyc(0, 0, 0, 1, 16'h5678, 0);
        chk("t5_avail0", 32'(io.in_avail), 0);
        chk("t5_ready1", 32'(io.ext_in_ready), 1);
        idle();
        chk("t5_avail2", 32'(io.in_avail), 1);
        chk("t5_data2", 32'(io.in_data), 32'h5678);

        // 6: asynchronous reset mid-drain
        reset_seq();
        cyc(1, 16'hD001, 0, 1, 16'h5555, 0);
        cyc(1, 16'hD002, 0, 0, 0, 0);
        cyc(1, 16'hD003, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t6_count", 32'(io.out_count), 2);
        chk("t6_avail", 32'(io.in_avail), 1);
        #2;
        Reset_n = 0;
        model_clear();
        #1;
        chk("t6_z_count", 32'(io.out_count), 0);
        chk("t6_z_valid", 32'(io.ext_valid), 0);
        chk("t6_z_data", 32'(io.ext_data), 0);
        chk("t6_z_avail", 32'(io.in_avail), 0);
        chk("t6_z_indata", 32'(io.in_data), 0);
        chk("t6_z_ready", 32'(io.ext_in_ready), 0);
        reset_seq();
        idle();
        chk("t6_valid", 32'(io.ext_valid), 0);
        chk("t6_ready", 32'(io.ext_in_ready), 1);

        // randomized traffic, alternating heavy-write and heavy-drain phases
        reset_seq();
        for (int i = 0; i < 3000; i++) begin
            bit heavy = (i / 200) % 2 == 0;
            cyc(bit'($urandom_range(0, heavy ? 3 : 9) != 0 ? heavy : !heavy),
                16'($urandom),
                bit'($urandom_range(0, heavy ? 3 : 1) == 0 ? 1 : !heavy),
                bit'($urandom_range(0, 2) == 0),
                16'($urandom),
                bit'($urandom_range(0, 2) == 0));
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lime_io_bridge.md
Name: lime_io_bridge

Overview:
- Peripheral stage that sits directly at the processor core's I/O boundary.
- Consumes the core's 16-bit output word and buffers it in a small FIFO. Drains it to an external consumer over valid/ready.
- On the input side, captures one external word via valid/ready into a holding register that drives the core's 16-bit input.
- Decouples a core running at instruction pace from slow or bursty external devices.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).
- WIDTH, 16, data width of both directions; fixed at 16 for the core.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- out_data  in  WIDTH  word from the core's output port.
- out_wr  in  1  core write strobe; one word per high cycle.
- out_full  out  1  FIFO full (count == DEPTH).
- out_count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- out_ovf  out  1  sticky: a write was dropped because the FIFO was full.
- ext_valid  out  1  head word is available to the consumer.
- ext_data  out  WIDTH  head word (show-ahead).
- ext_ready  in  1  consumer accepts the head word this cycle.
- ext_in_valid  in  1  external producer offers a word.
- ext_in_data  in  WIDTH  offered word.
- ext_in_ready  out  1  holding register is empty and can capture.
- in_data  out  WIDTH  holding register contents, wired to the core input.
- in_avail  out  1  holding register holds an unread word.
- in_rd  in  1  core consumed in_data; clears in_avail.

Behaviour:
- Reset (async assert, sync release on CLK), all state cleared:
  - Pointers cleared.
  - out_count = 0, out_full = 0, out_ovf = 0.
  - ext_valid = 0, ext_data = 0.
  - in_data = 0, in_avail = 0.
  - ext_in_ready = 1 the first cycle after release.
  - Reset mid-operation discards all buffered words, with no partial handshake.
- Push and pop qualifiers:
  - push = out_wr & (!out_full | pop).
  - pop = ext_valid & ext_ready.
- Occupancy update:
  - out_count increments on push-only and decrements on pop-only.
  - It is unchanged on push+pop or when idle.
- Pointers wrap modulo DEPTH.
- Full with write:
  - out_wr while full with no pop drops the word, sets out_ovf, and leaves the FIFO unchanged.
  - out_ovf clears only on reset.
- Full with simultaneous pop: out_wr while full with a pop accepts the word; the count stays at DEPTH.
- Empty with simultaneous push: the word appears on ext_data/ext_valid the next cycle (latency 1, no combinational bypass).
  - ext_ready is ignored while ext_valid = 0.
- Hold rule: ext_data and ext_valid are stable while ext_valid = 1 and ext_ready = 0.
- FIFO ordering: words are delivered strictly in push order.
- Input state machine has two states:
  - EMPTY: ext_in_ready = 1, in_avail = 0.
  - HELD: ext_in_ready = 0, in_avail = 1.
- Input transitions:
  - EMPTY→HELD on ext_in_valid; in_data captures ext_in_data at that edge.
  - HELD→EMPTY on in_rd.
  - in_data keeps its last value after in_rd.
  - in_rd in EMPTY has no effect.
  - Back-to-back inputs need at least one EMPTY cycle between captures.
- ext_in_ready is registered state only; it has no combinational path from in_rd.
- The input and output paths are fully independent.

Optional Feature:
- Macro: LIME_IO_OVF_COUNT_EN.
- Defined:
  - Adds output port ovf_count (8 bits), reset 0.
  - It increments on every dropped write and saturates at 255.
  - out_ovf = (ovf_count != 0).
- Undefined: the port is absent; out_ovf is a 1-bit sticky flag only.

Test Plan:
1. Reset, then write 0x1111, 0x2222, 0x3333 with ext_ready = 0 -> out_count = 3, ext_valid = 1, ext_data = 0x1111. Raise ext_ready for 3 cycles -> consumer receives 0x1111, 0x2222, 0x3333, then ext_valid = 0.
2. Write 5 words (0xA000..0xA004) with ext_ready = 0 and DEPTH = 4 -> out_full = 1, out_ovf = 1, 0xA004 lost. Drain -> exactly 0xA000..0xA003 (ovf_count = 1 with the macro defined).
3. FIFO full and ext_ready = 1, out_wr with 0xBEEF in the same cycle -> out_count stays 4, no overflow, 0xBEEF emerges last.
4. Empty FIFO: write 0x0042 with ext_ready = 1 held -> ext_valid rises exactly one cycle later with 0x0042, and pops on that cycle.
5. ext_in_valid with 0x1234, held for 3 cycles -> captured on the first edge, then ext_in_ready = 0 and in_avail = 1. Offer 0x5678 -> ignored. in_rd -> in_avail = 0, ext_in_ready = 1, and 0x5678 is captured the next cycle.
6. Assert Reset_n low asynchronously mid-drain with 2 words queued and in_avail = 1 -> all outputs are zero immediately (ext_in_ready = 0 while in reset). After release: ext_valid = 0, ext_in_ready = 1.
